// File: rtl/uart_rx.sv
// 16x-oversampling 8N1 UART receiver with framing-error and break recovery.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       received,
  output logic       framing_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic          rx_s1, rx_sync;
  logic [TW-1:0] tick_cnt, tick_cnt_n;
  logic          tick;
  logic [3:0]    sample_cnt, sample_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    data_n;
  logic          recv_n, ferr_n;
  logic          mid_sample;
`ifdef UART_RX_PARITY_EN
  logic          par_bit, par_bit_n, perr_n, par_bad;
  assign par_bad = ^{shift, par_bit};
`endif

  assign tick       = (tick_cnt == TICK_LAST);
  assign mid_sample = tick && (sample_cnt == 4'd15);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1       <= 1'b1;
      rx_sync     <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      sample_cnt  <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      data_out    <= '0;
      received    <= 1'b0;
      framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rx_s1       <= rx;
      rx_sync     <= rx_s1;
      state       <= state_n;
      tick_cnt    <= tick_cnt_n;
      sample_cnt  <= sample_cnt_n;
      bit_idx     <= bit_idx_n;
      shift       <= shift_n;
      data_out    <= data_n;
      received    <= recv_n;
      framing_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bit     <= par_bit_n;
      parity_err  <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    sample_cnt_n = tick ? sample_cnt + 4'd1 : sample_cnt;
    bit_idx_n    = bit_idx;
    shift_n      = shift;
    data_n       = data_out;
    recv_n       = 1'b0;
    ferr_n       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n    = par_bit;
    perr_n       = 1'b0;
`endif
    // Counter idles at zero so the first tick lands TICK_DIV clocks after the start edge.
    if (state == IDLE) tick_cnt_n = '0;
    else               tick_cnt_n = tick ? '0 : tick_cnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_n      = START;
          sample_cnt_n = '0;
        end
      end
      START: begin
        if (tick && sample_cnt == 4'd7) begin
          if (!rx_sync) begin
            state_n      = DATA;
            sample_cnt_n = '0;
            bit_idx_n    = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      DATA: begin
        if (mid_sample) begin
          shift_n[bit_idx] = rx_sync;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_sample) begin
          par_bit_n = rx_sync;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (mid_sample) begin
`ifdef UART_RX_PARITY_EN
          perr_n = par_bad;
`endif
          if (rx_sync) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (!par_bad) begin
              data_n = shift;
              recv_n = 1'b1;
            end
`else
            data_n = shift;
            recv_n = 1'b1;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level timing model plus directed scenarios.
module tb_uart_rx;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 1683;
`else
  localparam int LAT = 1523;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       received;
  logic       framing_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_out   (data_out),
    .received   (received),
    .framing_err(framing_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic       recv;
    logic       ferr;
    logic       perr;
    logic [7:0] b;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  logic       rst_q = 1'b0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_recv = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         last_recv_cyc = 0;
  logic [7:0] fall_data = '0;
  logic       prev_recv = 1'b0;
  logic [7:0] model_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // Model: each frame's outcome appears a fixed latency after its start edge.
  always @(negedge clk) begin
    logic e_recv, e_ferr, e_perr;
    ev_t  ev;
    if (cyc > 0) begin
      e_recv = 1'b0;
      e_ferr = 1'b0;
      e_perr = 1'b0;
      if (!rst_q) begin
        model_data = '0;
        chk("busy_rst", busy, 1'b0);
      end else if (q.size() > 0 && q[0].t == cyc) begin
        ev = q.pop_front();
        e_recv = ev.recv;
        e_ferr = ev.ferr;
        e_perr = ev.perr;
        if (ev.recv) model_data = ev.b;
      end
      chk("received", received, e_recv);
      chk("framing_err", framing_err, e_ferr);
      chk("data_out", data_out, model_data);
`ifdef UART_RX_PARITY_EN
      chk("parity_err", parity_err, e_perr);
      if (parity_err === 1'b1) n_perr++;
`endif
      if (received === 1'b1) begin
        n_recv++;
        last_recv_cyc = cyc;
      end
      if (framing_err === 1'b1) n_ferr++;
      if (prev_recv && received === 1'b0) fall_data = data_out;
      prev_recv = (received === 1'b1);
    end
  end

  // Drives one frame; abort_at >= 0 pulses reset midway through that bit and idles the line.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic flip_par,
                            input int abort_at);
    logic fb [11];
    int   nb;
    ev_t  e;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = b[i];
    nb = 9;
`ifdef UART_RX_PARITY_EN
    fb[nb] = (^b) ^ flip_par;
    nb++;
`endif
    fb[nb] = stop_bit;
    nb++;
    if (abort_at < 0) begin
      e.t    = cyc + LAT;
      e.recv = stop_bit & ~flip_par;
      e.ferr = ~stop_bit;
      e.perr = flip_par;
      e.b    = b;
      q.push_back(e);
    end
    for (int i = 0; i < nb; i++) begin
      rx = fb[i];
      if (i == abort_at) begin
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rx = 1'b1;
        return;
      end
      repeat (160) @(negedge clk);
    end
  endtask

  initial begin
    int t0, br, bf, bp;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_received", received, 1'b0);
    chk("rst_framing_err", framing_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    br = n_recv;
    t0 = cyc;
    send_frame(8'h57, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    chk("lat_57", last_recv_cyc - t0, LAT);
    chk("fall_data_57", fall_data, 8'h57);
    chk("cnt_57", n_recv - br, 1);

    br = n_recv;
    send_frame(8'h69, 1'b1, 1'b0, -1);
    send_frame(8'h6B, 1'b1, 1'b0, -1);
    send_frame(8'h73, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    chk("cnt_b2b", n_recv - br, 3);
    chk("data_b2b", data_out, 8'h73);

    br = n_recv;
    bf = n_ferr;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("busy_glitch", busy, 1'b1);
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch_recv", n_recv - br, 0);
    chk("glitch_ferr", n_ferr - bf, 0);
    chk("busy_idle", busy, 1'b0);
    send_frame(8'h4B, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    chk("data_4b", data_out, 8'h4B);

    br = n_recv;
    bf = n_ferr;
    send_frame(8'h53, 1'b0, 1'b0, -1);
    repeat (3000) @(negedge clk);
    chk("busy_break", busy, 1'b1);
    rx = 1'b1;
    repeat (320) @(negedge clk);
    chk("break_ferr", n_ferr - bf, 1);
    chk("break_recv", n_recv - br, 0);
    chk("break_data", data_out, 8'h4B);
    send_frame(8'h49, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    chk("data_49", data_out, 8'h49);

    br = n_recv;
    send_frame(8'h77, 1'b1, 1'b0, 5);
    repeat (2000) @(negedge clk);
    chk("abort_recv", n_recv - br, 0);
    chk("abort_data", data_out, 8'h00);
    send_frame(8'h77, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    chk("data_77", data_out, 8'h77);

`ifdef UART_RX_PARITY_EN
    br = n_recv;
    send_frame(8'h55, 1'b1, 1'b0, -1);
    repeat (20) @(negedge clk);
    chk("par_good_recv", n_recv - br, 1);
    chk("par_good_data", data_out, 8'h55);
    br = n_recv;
    bp = n_perr;
    send_frame(8'h55, 1'b1, 1'b1, -1);
    repeat (20) @(negedge clk);
    chk("par_bad_perr", n_perr - bp, 1);
    chk("par_bad_recv", n_recv - br, 0);
`else
    bp = n_perr;
    chk("no_perr", bp, 0);
`endif

    repeat (50) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
